// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves source operands (EX > MEM > WB forwarding > regfile),
// detects load-use hazards, inserts bubbles and registers the ID/EX payload.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [4:0]        rf_rd_addr1,
    output logic [4:0]        rf_rd_addr2,
    input  logic [XLEN-1:0]   rf_rd_data1,
    input  logic [XLEN-1:0]   rf_rd_data2,
    input  logic [XLEN-1:0]   ex_alu_fwd,
    input  logic              mem_fwd_we,
    input  logic [4:0]        mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [4:0]        ex_rd,
    output logic              ex_rd_we,
    output logic              ex_is_load,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ex_valid_r;
    logic [XLEN-1:0]   ex_pc_r;
    logic [XLEN-1:0]   ex_imm_r;
    logic [XLEN-1:0]   ex_rs1_val_r;
    logic [XLEN-1:0]   ex_rs2_val_r;
    logic [4:0]        ex_rd_r;
    logic              ex_rd_we_r;
    logic              ex_is_load_r;
    logic [CTRL_W-1:0] ex_ctrl_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              adv_s;
    logic              hz_s;
    logic              accept_s;
    logic              ex_fwd_ok_s;
    logic [XLEN-1:0]   rs1_val_s;
    logic [XLEN-1:0]   rs2_val_s;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // x0 is hard-wired zero and must never pick up a forwarded value.
    function automatic logic [XLEN-1:0] resolve_src(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_ok,
        input logic [4:0]      ex_dst,
        input logic [XLEN-1:0] ex_data,
        input logic            m_we,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_data,
        input logic            w_we,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_data
    );
        logic [XLEN-1:0] val;
        if (src == 5'd0) begin
            val = {XLEN{1'b0}};
        end else if (ex_ok && (ex_dst == src)) begin
            val = ex_data;
        end else if (m_we && (m_rd == src)) begin
            val = m_data;
        end else if (w_we && (w_rd == src)) begin
            val = w_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    assign rf_rd_addr1 = id_rs1;
    assign rf_rd_addr2 = id_rs2;

    // Handshake, hazard detection and operand resolution.
    always_comb begin
        adv_s       = !ex_valid_r || ex_ready;
        hz_s        = ex_valid_r && ex_is_load_r && ex_rd_we_r && (ex_rd_r != 5'd0) && id_valid &&
                      ((id_use_rs1 && (id_rs1 == ex_rd_r)) || (id_use_rs2 && (id_rs2 == ex_rd_r)));
        id_ready    = !rst && !flush && adv_s && !hz_s;
        accept_s    = id_valid && id_ready;
        ex_fwd_ok_s = ex_valid_r && ex_rd_we_r && !ex_is_load_r;
        rs1_val_s   = resolve_src(id_rs1, rf_rd_data1, ex_fwd_ok_s, ex_rd_r, ex_alu_fwd,
                                  mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_we, wb_rd, wb_data);
        rs2_val_s   = resolve_src(id_rs2, rf_rd_data2, ex_fwd_ok_s, ex_rd_r, ex_alu_fwd,
                                  mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_we, wb_rd, wb_data);
    end

    // ID/EX payload register; holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r   <= 1'b0;
            ex_pc_r      <= {XLEN{1'b0}};
            ex_imm_r     <= {XLEN{1'b0}};
            ex_rs1_val_r <= {XLEN{1'b0}};
            ex_rs2_val_r <= {XLEN{1'b0}};
            ex_rd_r      <= 5'd0;
            ex_rd_we_r   <= 1'b0;
            ex_is_load_r <= 1'b0;
            ex_ctrl_r    <= {CTRL_W{1'b0}};
        end else if (flush) begin
            ex_valid_r <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r   <= 1'b1;
            ex_pc_r      <= id_pc;
            ex_imm_r     <= id_imm;
            ex_rs1_val_r <= rs1_val_s;
            ex_rs2_val_r <= rs2_val_s;
            ex_rd_r      <= id_rd;
            ex_rd_we_r   <= id_rd_we;
            ex_is_load_r <= id_is_load;
            ex_ctrl_r    <= id_ctrl;
        end else if (adv_s) begin
            ex_valid_r <= 1'b0;
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (hz_s && !flush && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign ex_valid   = ex_valid_r;
    assign ex_pc      = ex_pc_r;
    assign ex_imm     = ex_imm_r;
    assign ex_rs1_val = ex_rs1_val_r;
    assign ex_rs2_val = ex_rs2_val_r;
    assign ex_rd      = ex_rd_r;
    assign ex_rd_we   = ex_rd_we_r;
    assign ex_is_load = ex_is_load_r;
    assign ex_ctrl    = ex_ctrl_r;
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: a cycle model checked on every negedge plus
// hand-computed expectations for forwarding, load-use, backpressure, flush and saturation.
module tb_id_ex_operand_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_imm;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_rd_we;
    logic              id_is_load;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        rf_rd_addr1;
    logic [4:0]        rf_rd_addr2;
    logic [XLEN-1:0]   rf_rd_data1;
    logic [XLEN-1:0]   rf_rd_data2;
    logic [XLEN-1:0]   ex_alu_fwd;
    logic              mem_fwd_we;
    logic [4:0]        mem_fwd_rd;
    logic [XLEN-1:0]   mem_fwd_data;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              ex_ready;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_rs1_val;
    logic [XLEN-1:0]   ex_rs2_val;
    logic [4:0]        ex_rd;
    logic              ex_rd_we;
    logic              ex_is_load;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    logic [XLEN-1:0] rf [32];
    int checks   = 0;
    int failures = 0;

    id_ex_operand_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .id_ctrl(id_ctrl),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .ex_alu_fwd(ex_alu_fwd), .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd),
        .mem_fwd_data(mem_fwd_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    // Register file behaves as a combinational read of the bench array.
    assign rf_rd_data1 = rf[rf_rd_addr1];
    assign rf_rd_data2 = rf[rf_rd_addr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic              model_on = 1'b0;
    logic              m_valid;
    logic [XLEN-1:0]   m_pc, m_imm, m_r1, m_r2;
    logic [4:0]        m_rd;
    logic              m_we, m_ld;
    logic [CTRL_W-1:0] m_ctrl;
    logic [CNT_W-1:0]  m_cnt;

    function automatic logic [XLEN-1:0] m_operand(input logic [4:0] s);
        if (s == 5'd0) return 32'd0;
        if (m_valid && m_we && !m_ld && m_rd == s) return ex_alu_fwd;
        if (mem_fwd_we && mem_fwd_rd == s) return mem_fwd_data;
        if (wb_we && wb_rd == s) return wb_data;
        return rf[s];
    endfunction

    function automatic logic m_hz();
        return m_valid && m_ld && m_we && (m_rd != 5'd0) && id_valid &&
               ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
    endfunction

    function automatic logic m_ready();
        return !rst && !flush && (!m_valid || ex_ready) && !m_hz();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_on <= 1'b1;
            m_valid <= 1'b0; m_pc <= 32'd0; m_imm <= 32'd0; m_r1 <= 32'd0; m_r2 <= 32'd0;
            m_rd <= 5'd0; m_we <= 1'b0; m_ld <= 1'b0; m_ctrl <= 16'd0; m_cnt <= 4'd0;
        end else begin
            if (m_hz() && !flush && m_cnt != 4'hF) m_cnt <= m_cnt + 4'd1;
            if (flush) m_valid <= 1'b0;
            else if (id_valid && m_ready()) begin
                m_valid <= 1'b1; m_pc <= id_pc; m_imm <= id_imm;
                m_r1 <= m_operand(id_rs1); m_r2 <= m_operand(id_rs2);
                m_rd <= id_rd; m_we <= id_rd_we; m_ld <= id_is_load; m_ctrl <= id_ctrl;
            end else if (!m_valid || ex_ready) m_valid <= 1'b0;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("ex_valid", ex_valid, m_valid);
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rs1_val", ex_rs1_val, m_r1);
            chk("ex_rs2_val", ex_rs2_val, m_r2);
            chk("ex_rd", ex_rd, m_rd);
            chk("ex_rd_we", ex_rd_we, m_we);
            chk("ex_is_load", ex_is_load, m_ld);
            chk("ex_ctrl", ex_ctrl, m_ctrl);
            chk("stall_cnt", stall_cnt, m_cnt);
            chk("id_ready", id_ready, m_ready());
            chk("rf_rd_addr1", rf_rd_addr1, id_rs1);
            chk("rf_rd_addr2", rf_rd_addr2, id_rs2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic ld);
        id_valid = 1'b1; id_pc = pc; id_imm = pc + 32'h8000; id_ctrl = pc[15:0] ^ 16'hA5A5;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_we = we; id_is_load = ld;
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic ld);
        drive(pc, rs1, rs2, rd, we, ld);
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[5] = 32'h11;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_pc = 32'd0; id_imm = 32'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd_we = 1'b0; id_is_load = 1'b0; id_ctrl = 16'd0; ex_alu_fwd = 32'd0;
        mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; ex_ready = 1'b1;

        // Reset held two cycles
        step(); step();
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_id_ready", id_ready, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 4'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_rs1_val", ex_rs1_val, 32'd0);
        chk("rst_ex_ctrl", ex_ctrl, 16'd0);
        rst = 1'b0;
        #1 chk("rel_id_ready", id_ready, 1'b1);

        // Forwarding priority on x5
        issue(32'h100, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h22;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h33;
        ex_alu_fwd = 32'h44;
        issue(32'h104, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
        chk("fwd_ex", ex_rs1_val, 32'h44);
        chk("fwd_ex_rs2_rf", ex_rs2_val, 32'h1006);
        issue(32'h108, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
        chk("fwd_mem", ex_rs1_val, 32'h33);
        mem_fwd_we = 1'b0;
        issue(32'h10C, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
        chk("fwd_wb", ex_rs1_val, 32'h22);
        wb_we = 1'b0;
        issue(32'h110, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
        chk("fwd_rf", ex_rs1_val, 32'h11);

        // x0 never forwarded
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hDEAD;
        issue(32'h114, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        chk("x0_rs1", ex_rs1_val, 32'd0);
        chk("x0_rs2", ex_rs2_val, 32'd0);
        mem_fwd_we = 1'b0;

        // Load-use: lw x3 then add x4,x3,x1
        issue(32'h120, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
        drive(32'h124, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0);
        #1 chk("lu_id_ready_low", id_ready, 1'b0);
        step();
        chk("lu_bubble", ex_valid, 1'b0);
        chk("lu_stall_cnt", stall_cnt, 4'd1);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h333;
        #1 chk("lu_id_ready_back", id_ready, 1'b1);
        step();
        chk("lu_issue_valid", ex_valid, 1'b1);
        chk("lu_issue_pc", ex_pc, 32'h124);
        chk("lu_issue_rs1", ex_rs1_val, 32'h333);
        chk("lu_issue_rs2", ex_rs2_val, 32'h1001);
        mem_fwd_we = 1'b0;

        // Backpressure for three cycles
        ex_ready = 1'b0;
        drive(32'h200, 5'd2, 5'd0, 5'd8, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_pc", ex_pc, 32'h124);
            chk("bp_hold_rs1", ex_rs1_val, 32'h333);
            chk("bp_id_ready", id_ready, 1'b0);
        end
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", id_ready, 1'b1);
        step();
        chk("bp_next_pc", ex_pc, 32'h200);

        // Flush during a load-use stall held by backpressure
        issue(32'h300, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        ex_ready = 1'b0;
        drive(32'h304, 5'd0, 5'd9, 5'd10, 1'b1, 1'b0);
        step(); step(); step();
        chk("hz_hold_pc", ex_pc, 32'h300);
        chk("hz_cnt", stall_cnt, 4'd4);
        flush = 1'b1;
        step();
        chk("flush_valid", ex_valid, 1'b0);
        chk("flush_cnt", stall_cnt, 4'd4);
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        step();

        // Counter saturation
        issue(32'h310, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        ex_ready = 1'b0;
        drive(32'h314, 5'd0, 5'd9, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step();
        chk("sat_cnt", stall_cnt, 4'hF);
        flush = 1'b1;
        step();
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        step();
        chk("sat_cnt_after_flush", stall_cnt, 4'hF);
        chk("sat_valid", ex_valid, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
